fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage of the RV32I core; feeds the decode/control stage.
//   Holds the PC and issues one word request per instruction over a req/gnt/rvalid imem port.
//   Presents the fetched word to decode with a valid/ready handshake.
//   Selects the next PC from decode's npc_op/npc_target when decode accepts the word.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset
//   NOP_INST   32'h0000_0013   word driven on inst when no valid instruction (addi x0,x0,0)
// PORTS
//   clk         in   1   core clock, all state updates on rising edge
//   rst         in   1   synchronous, active-high reset
//   imem_req    out  1   fetch request, held until imem_gnt
//   imem_addr   out  32  word-aligned fetch address (= pc)
//   imem_gnt    in   1   request accepted this cycle
//   imem_rvalid in   1   read data valid, earliest 1 cycle after gnt
//   imem_rdata  in   32  instruction word
//   inst_valid  out  1   inst/pc/pc4 hold a fetched instruction
//   inst        out  32  instruction to decode; NOP_INST when inst_valid=0
//   pc          out  32  address of inst
//   pc4         out  32  pc+4, link value for jal/jalr writeback
//   id_ready    in   1   decode consumes inst this cycle
//   npc_op      in   1   from decode: 1 = next pc is npc_target, 0 = pc+4
//   npc_target  in   32  branch/jump target (ALU result)
//   fetch_err   out  1   misaligned target taken; sticky until rst
//   instr_cnt   out  32  count of consumed instructions, wraps 2^32-1 -> 0
// BEHAVIOUR
//   Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, inst=NOP_INST, inst_valid=0,
//     fetch_err=0, instr_cnt=0; imem_req forced 0 while rst is high.
//   States: FETCH, WAIT, VALID, ERR.
//   FETCH: imem_req=1, imem_addr=pc. imem_gnt -> WAIT. rvalid here ignored.
//   WAIT: imem_req=0. On imem_rvalid: inst<=imem_rdata, inst_valid<=1 -> VALID.
//   VALID: inst_valid=1, outputs stable until id_ready. On id_ready (consume):
//     nxt = npc_op ? {npc_target[31:1],1'b0} : pc+4 (jalr bit0 clear);
//     instr_cnt<=instr_cnt+1; inst<=NOP_INST; inst_valid<=0; pc<=nxt;
//     nxt[1]=1 -> ERR (pc still updated), else -> FETCH.
//   ERR: fetch_err=1, imem_req=0, inst_valid=0; leave only via rst.
//   npc_op/npc_target sampled only in the consume cycle; ignored otherwise.
//   id_ready while inst_valid=0: no effect.
//   Latency: gnt at cycle t, rvalid at t+1 -> inst_valid=1 at t+2; consume at t+2
//     -> imem_req for next pc at t+3. Peak 1 instr / 3 cycles; no speculation.
//   pc4 = pc+4 combinational, mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//   Reset mid-operation: pending gnt/rvalid dropped; imem shares rst so no stale
//     rvalid reaches the new WAIT.
//   Only one request outstanding; rvalid outside WAIT is a protocol error, ignored.
// TESTING
//   rst, gnt same cycle as req, rvalid next, rdata=0x00500093, id_ready=1 ->
//     imem_addr=0x0 at FETCH, inst=0x00500093 valid 2 cycles after gnt, next addr 0x4.
//   Hold id_ready=0 for 5 cycles in VALID -> inst/pc constant, no imem_req, instr_cnt unchanged.
//   Consume at pc=0x10 with npc_op=1, npc_target=0x41 -> next imem_addr=0x40.
//   Consume with npc_op=1, npc_target=0x102 -> pc=0x102, fetch_err=1, req stays 0 until rst.
//   gnt delayed 3 cycles, rvalid delayed 4 -> imem_req/addr held 4 cycles, inst stays NOP until rvalid.
//   rst asserted in WAIT, then rvalid -> ignored, state FETCH, pc=RESET_PC, instr_cnt=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem word request per instruction,
// and hands the fetched word to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        id_ready,
  input  logic        npc_op,
  input  logic [31:0] npc_target,
  output logic        fetch_err,
  output logic [31:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      state_r;
  logic        imem_req_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        inst_valid_r;
  logic        fetch_err_r;
  logic [31:0] instr_cnt_r;
  logic [31:0] nxt_pc_s;

  // Jump targets drop bit 0 (jalr semantics); bit 1 is left intact so misalignment is visible.
  function automatic logic [31:0] next_pc(input logic op, input logic [31:0] target,
                                          input logic [31:0] cur);
    logic [31:0] res;
    if (op) begin
      res = target & 32'hFFFF_FFFE;
    end else begin
      res = cur + 32'd4;
    end
    return res;
  endfunction

  assign nxt_pc_s = next_pc(npc_op, npc_target, pc_r);

  // Fetch FSM together with all of its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_FETCH;
      imem_req_r   <= 1'b1;
      pc_r         <= RESET_PC;
      inst_r       <= NOP_INST;
      inst_valid_r <= 1'b0;
      fetch_err_r  <= 1'b0;
      instr_cnt_r  <= 32'd0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_gnt) begin
            state_r    <= S_WAIT;
            imem_req_r <= 1'b0;
          end else begin
            state_r    <= S_FETCH;
            imem_req_r <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_r      <= S_VALID;
            inst_r       <= imem_rdata;
            inst_valid_r <= 1'b1;
          end else begin
            state_r      <= S_WAIT;
          end
        end
        S_VALID: begin
          if (id_ready) begin
            pc_r         <= nxt_pc_s;
            inst_r       <= NOP_INST;
            inst_valid_r <= 1'b0;
            instr_cnt_r  <= instr_cnt_r + 32'd1;
            // A halfword-aligned target is unrecoverable without a reset.
            if (nxt_pc_s[1]) begin
              state_r     <= S_ERR;
              fetch_err_r <= 1'b1;
              imem_req_r  <= 1'b0;
            end else begin
              state_r     <= S_FETCH;
              imem_req_r  <= 1'b1;
            end
          end else begin
            state_r <= S_VALID;
          end
        end
        S_ERR: begin
          state_r      <= S_ERR;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
          fetch_err_r  <= 1'b1;
        end
        default: begin
          state_r      <= S_ERR;
          imem_req_r   <= 1'b0;
          inst_r       <= NOP_INST;
          inst_valid_r <= 1'b0;
          fetch_err_r  <= 1'b1;
        end
      endcase
    end
  end

  // The request register comes out of reset high, so it is masked while reset is held.
  assign imem_req   = imem_req_r & ~rst;
  assign imem_addr  = pc_r;
  assign pc         = pc_r;
  assign pc4        = pc_r + 32'd4;
  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign fetch_err  = fetch_err_r;
  assign instr_cnt  = instr_cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of fetch/consume transactions with an
// expected-instruction scoreboard, plus directed error and mid-operation reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        id_ready;
  logic        npc_op;
  logic [31:0] npc_target;
  logic        fetch_err;
  logic [31:0] instr_cnt;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc4(pc4),
    .id_ready(id_ready), .npc_op(npc_op), .npc_target(npc_target),
    .fetch_err(fetch_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        op;
    logic [31:0] tgt;
    int          gnt_dly;
    int          rv_dly;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t        vecs [8];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          seen;
    exp_t        e;
    logic [31:0] tgt;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (imem_req) seen = 1'b1;
      else @(negedge clk);
    end
    chk("req_seen", {31'd0, seen}, 32'd1);
    chk("imem_addr", imem_addr, exp_pc);
    for (int i = 0; i < v.gnt_dly; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, exp_pc);
      chk("nop_before_gnt", inst, NOP);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("req_drop_wait", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < v.rv_dly; i++) begin
      chk("nop_wait_rv", inst, NOP);
      chk("invalid_wait_rv", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = v.rdata;
    e.pc = exp_pc;
    e.inst = v.rdata;
    sb.push_back(e);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("pc", pc, e.pc);
      chk("pc4", pc4, e.pc + 32'd4);
    end
    // Decode stalls; next-pc inputs carry junk that must be ignored.
    for (int i = 0; i < v.hold; i++) begin
      id_ready   = 1'b0;
      npc_op     = 1'b1;
      npc_target = 32'h0000_0002;
      @(negedge clk);
      chk("hold_inst", inst, e.inst);
      chk("hold_pc", pc, e.pc);
      chk("hold_noreq", {31'd0, imem_req}, 32'd0);
      chk("hold_cnt", instr_cnt, exp_cnt);
    end
    id_ready   = 1'b1;
    npc_op     = v.op;
    npc_target = v.tgt;
    @(negedge clk);
    id_ready = 1'b0;
    npc_op   = 1'b0;
    tgt      = v.tgt;
    exp_pc   = v.op ? {tgt[31:1], 1'b0} : exp_pc + 32'd4;
    exp_cnt  = exp_cnt + 32'd1;
    chk("cnt_after", instr_cnt, exp_cnt);
    chk("pc_after", pc, exp_pc);
    chk("invalid_after", {31'd0, inst_valid}, 32'd0);
    chk("nop_after", inst, NOP);
    chk("err_after", {31'd0, fetch_err}, {31'd0, exp_pc[1]});
    chk("req_after", {31'd0, imem_req}, {31'd0, ~exp_pc[1]});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    chk({tag, "_cnt"}, instr_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               rdata          op    tgt            gnt rv hold
    vecs[0] = '{32'h0050_0093, 1'b0, 32'h0000_0000, 0, 0, 0};
    vecs[1] = '{32'h0010_0113, 1'b0, 32'h0000_0000, 0, 0, 5};
    vecs[2] = '{32'h0020_8193, 1'b0, 32'h0000_0000, 1, 2, 1};
    vecs[3] = '{32'h0031_0213, 1'b0, 32'h0000_0000, 3, 4, 0};
    vecs[4] = '{32'h0400_006F, 1'b1, 32'h0000_0041, 0, 0, 2};
    vecs[5] = '{32'h0000_8067, 1'b1, 32'hFFFF_FFFD, 2, 1, 0};
    vecs[6] = '{32'h0000_0013, 1'b0, 32'h0000_0000, 0, 0, 0};
    vecs[7] = '{32'h1020_006F, 1'b1, 32'h0000_0102, 0, 0, 0};

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    id_ready = 1'b0; npc_op = 1'b0; npc_target = 32'd0;
    exp_pc = 32'd0; exp_cnt = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst0");
    chk("rst0_pc4", pc4, 32'h0000_0004);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Error state is sticky and deaf to handshakes.
    for (int i = 0; i < 4; i++) begin
      id_ready = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; npc_op = 1'b0;
      @(negedge clk);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_noreq", {31'd0, imem_req}, 32'd0);
      chk("err_invalid", {31'd0, inst_valid}, 32'd0);
      chk("err_cnt", instr_cnt, exp_cnt);
      chk("err_pc", pc, 32'h0000_0102);
    end
    id_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("rst1");
    rst = 1'b0;
    exp_pc = 32'd0; exp_cnt = 32'd0;
    @(negedge clk);

    // Reset while waiting for read data: the late rvalid must be dropped.
    chk("w_req", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("w_valid", {31'd0, inst_valid}, 32'd0);
    chk("w_inst", inst, NOP);
    chk("w_req_again", {31'd0, imem_req}, 32'd1);
    chk("w_addr", imem_addr, 32'd0);
    chk("w_cnt", instr_cnt, 32'd0);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    chk("idle_ready_cnt", instr_cnt, 32'd0);
    chk("idle_ready_pc", pc, 32'd0);

    run_vec(vecs[0]);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
